lcd_line_timer: RTL and testbench

LCD_LINE_TIMER -- requirements
Module: lcd_line_timer

---
 rtl/lcd_line_timer.sv | 144 ++++++++++++++
 tb/tb_lcd_line_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_timer.sv
// LCD scanline/frame timer with the LCDC, STAT, LY and LYC bus registers.
// Produces the STAT mode, the current line, and the vblank/STAT interrupt pulses.
module lcd_line_timer #(
   parameter int LINE_CYCLES = 456,
   parameter int FRAME_LINES = 154,
   parameter int VBLANK_LINE = 144,
   parameter int OAM_CYCLES  = 80,
   parameter int XFER_CYCLES = 172
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tick,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [7:0]  ly,
   output logic [1:0]  mode,
   output logic        vblank_irq,
   output logic        stat_irq
);

   localparam int DOT_W = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
   localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(LINE_CYCLES - 1);
   localparam logic [DOT_W-1:0] OAM_END  = DOT_W'(OAM_CYCLES);
   localparam logic [DOT_W-1:0] XFER_END = DOT_W'(OAM_CYCLES + XFER_CYCLES);
   localparam logic [7:0] LY_LAST = 8'(FRAME_LINES - 1);
   localparam logic [7:0] LY_VBL  = 8'(VBLANK_LINE);

   localparam logic [15:0] ADDR_LCDC = 16'hFF40;
   localparam logic [15:0] ADDR_STAT = 16'hFF41;
   localparam logic [15:0] ADDR_LY   = 16'hFF44;
   localparam logic [15:0] ADDR_LYC  = 16'hFF45;

   logic [7:0]       lcdc_reg;
   logic [7:0]       lcdc_next;
   logic [6:3]       stat_reg;
   logic [7:0]       lyc_reg;
   logic [7:0]       ly_reg;
   logic [DOT_W-1:0] dot_reg;
   logic             stat_cond_reg;
   logic             vbl_cond_reg;
   logic             stat_irq_reg;
   logic             vblank_irq_reg;

   logic       sel_lcdc, sel_stat, sel_ly, sel_lyc, sel_any;
   logic       enabled;
   logic       coincidence;
   logic       stat_cond;
   logic       vbl_cond;
   logic [1:0] mode_dec;
   logic [7:0] rd_data;

   assign sel_lcdc = (addr == ADDR_LCDC);
   assign sel_stat = (addr == ADDR_STAT);
   assign sel_ly   = (addr == ADDR_LY);
   assign sel_lyc  = (addr == ADDR_LYC);
   assign sel_any  = sel_lcdc | sel_stat | sel_ly | sel_lyc;

   assign lcdc_next = (mem_we && sel_lcdc) ? data_in : lcdc_reg;
   assign enabled   = lcdc_reg[7];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lcdc_reg <= 8'h00;
         stat_reg <= 4'h0;
         lyc_reg  <= 8'h00;
      end else begin
         lcdc_reg <= lcdc_next;
         if (mem_we && sel_stat) stat_reg <= data_in[6:3];
         if (mem_we && sel_lyc)  lyc_reg  <= data_in;
      end
   end

   // Clearing keys off the incoming LCDC value so a disable shows ly=0 on the very next clock;
   // advancing keys off the current value so a re-enable starts cleanly at dot 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dot_reg <= '0;
         ly_reg  <= 8'h00;
      end else if (!lcdc_next[7] || (mem_we && sel_ly)) begin
         dot_reg <= '0;
         ly_reg  <= 8'h00;
      end else if (enabled && tick) begin
         if (dot_reg == DOT_LAST) begin
            dot_reg <= '0;
            ly_reg  <= (ly_reg == LY_LAST) ? 8'h00 : ly_reg + 8'd1;
         end else begin
            dot_reg <= dot_reg + 1'b1;
         end
      end
   end

   always_comb begin
      mode_dec = 2'd0;
      if (enabled) begin
         if (ly_reg >= LY_VBL)         mode_dec = 2'd1;
         else if (dot_reg < OAM_END)   mode_dec = 2'd2;
         else if (dot_reg < XFER_END)  mode_dec = 2'd3;
         else                          mode_dec = 2'd0;
      end
   end

   assign coincidence = (ly_reg == lyc_reg);

   assign stat_cond = enabled & ((stat_reg[6] & coincidence)
                               | (stat_reg[5] & (mode_dec == 2'd2))
                               | (stat_reg[4] & (mode_dec == 2'd1))
                               | (stat_reg[3] & (mode_dec == 2'd0)));
   assign vbl_cond  = enabled & (ly_reg == LY_VBL);

   // Edge detectors: a source that hands over to another without a gap does not re-fire.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_cond_reg  <= 1'b0;
         vbl_cond_reg   <= 1'b0;
         stat_irq_reg   <= 1'b0;
         vblank_irq_reg <= 1'b0;
      end else begin
         stat_cond_reg  <= stat_cond;
         vbl_cond_reg   <= vbl_cond;
         stat_irq_reg   <= stat_cond & ~stat_cond_reg;
         vblank_irq_reg <= vbl_cond & ~vbl_cond_reg;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (sel_lcdc)     rd_data = lcdc_reg;
      else if (sel_stat) rd_data = {1'b1, stat_reg, coincidence, mode_dec};
      else if (sel_ly)   rd_data = ly_reg;
      else if (sel_lyc)  rd_data = lyc_reg;
   end

   assign data_oe    = mem_re & ~mem_we & sel_any;
   assign data_out   = data_oe ? rd_data : 8'h00;
   assign ly         = ly_reg;
   assign mode       = mode_dec;
   assign stat_irq   = stat_irq_reg & enabled;
   assign vblank_irq = vblank_irq_reg & enabled;

endmodule

// File: tb/tb_lcd_line_timer.sv
// Scoreboard bench for lcd_line_timer: stimulus queues expected samples and interrupt events,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_lcd_line_timer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  data_in = 8'h00;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  ly;
   logic [1:0]  mode;
   logic        vblank_irq;
   logic        stat_irq;

   lcd_line_timer dut (
      .clock(clock), .reset(reset), .tick(tick), .addr(addr), .data_in(data_in),
      .mem_we(mem_we), .mem_re(mem_re), .data_out(data_out), .data_oe(data_oe),
      .ly(ly), .mode(mode), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [7:0] ly;
      logic [1:0] mode;
      logic       oe;
      logic [7:0] dout;
   } samp_t;

   typedef struct {
      string      name;
      logic       is_vbl;
      logic [7:0] ly;
      logic [1:0] mode;
   } irq_t;

   samp_t samp_q[$];
   irq_t  irq_q[$];
   logic  sample_req = 1'b0;
   logic  done = 1'b0;
   logic  reported = 1'b0;
   int    tests = 0;
   int    fails = 0;

   // Monitor: compares queued samples and every interrupt pulse the DUT presents.
   always @(negedge clock) begin
      samp_t s;
      irq_t  e;
      logic  pulse;
      if (sample_req) begin
         tests++;
         if (samp_q.size() == 0) begin
            fails++;
            $display("FAIL sample_underflow: no expectation queued");
         end else begin
            s = samp_q.pop_front();
            if (ly !== s.ly || mode !== s.mode || data_oe !== s.oe || data_out !== s.dout) begin
               fails++;
               $display("FAIL %s: got ly=%02h mode=%0d oe=%b dout=%02h, want ly=%02h mode=%0d oe=%b dout=%02h",
                        s.name, ly, mode, data_oe, data_out, s.ly, s.mode, s.oe, s.dout);
            end else begin
               $display("[TB] ok %s: ly=%02h mode=%0d oe=%b dout=%02h", s.name, ly, mode, data_oe, data_out);
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         pulse = (k == 0) ? vblank_irq : stat_irq;
         if (pulse === 1'b1) begin
            tests++;
            if (irq_q.size() == 0) begin
               fails++;
               $display("FAIL irq_unexpected: got %s pulse at ly=%02h mode=%0d, want none",
                        (k == 0) ? "vblank" : "stat", ly, mode);
            end else begin
               e = irq_q.pop_front();
               if (e.is_vbl !== (k == 0) || ly !== e.ly || mode !== e.mode) begin
                  fails++;
                  $display("FAIL %s: got %s pulse at ly=%02h mode=%0d, want %s at ly=%02h mode=%0d",
                           e.name, (k == 0) ? "vblank" : "stat", ly, mode,
                           e.is_vbl ? "vblank" : "stat", e.ly, e.mode);
               end else begin
                  $display("[TB] ok %s: %s pulse at ly=%02h mode=%0d", e.name,
                           (k == 0) ? "vblank" : "stat", ly, mode);
               end
            end
         end
      end
      if (done && !reported) begin
         reported <= 1'b1;
         tests++;
         if (irq_q.size() != 0 || samp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d irq and %0d sample expectations unmatched, want 0 and 0",
                     irq_q.size(), samp_q.size());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic expect_state(string nm, logic [7:0] l, logic [1:0] m,
                               logic [15:0] a, logic re, logic oe, logic [7:0] d);
      samp_t s;
      s.name = nm; s.ly = l; s.mode = m; s.oe = oe; s.dout = d;
      samp_q.push_back(s);
      addr = a;
      mem_re = re;
      sample_req = 1'b1;
      @(posedge clock);
      #1;
      sample_req = 1'b0;
      mem_re = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic chk(string nm, logic [7:0] l, logic [1:0] m);
      expect_state(nm, l, m, 16'h0000, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic rd(string nm, logic [7:0] l, logic [1:0] m, logic [15:0] a, logic [7:0] d);
      expect_state(nm, l, m, a, 1'b1, 1'b1, d);
   endtask

   task automatic exp_irq(string nm, logic vbl, logic [7:0] l, logic [1:0] m);
      irq_t e;
      e.name = nm; e.is_vbl = vbl; e.ly = l; e.mode = m;
      irq_q.push_back(e);
   endtask

   task automatic wr(logic [15:0] a, logic [7:0] d);
      addr = a;
      data_in = d;
      mem_we = 1'b1;
      @(posedge clock);
      #1;
      mem_we = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic run(int n);
      tick = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      tick = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("reset_hold", 8'h00, 2'd0);
      reset = 1'b0;
      rd("reset_lcdc", 8'h00, 2'd0, 16'hFF40, 8'h00);
      rd("reset_stat", 8'h00, 2'd0, 16'hFF41, 8'h84);
      rd("reset_ly",   8'h00, 2'd0, 16'hFF44, 8'h00);
      rd("reset_lyc",  8'h00, 2'd0, 16'hFF45, 8'h00);
      expect_state("unmapped_read", 8'h00, 2'd0, 16'hFF42, 1'b1, 1'b0, 8'h00);

      // Line timing from enable.
      wr(16'hFF40, 8'h80);
      chk("enable_line0", 8'h00, 2'd2);
      run(80);
      chk("dot80_mode3", 8'h00, 2'd3);
      run(172);
      chk("dot252_mode0", 8'h00, 2'd0);
      run(204);
      chk("line1_mode2", 8'h01, 2'd2);

      // Coincidence source.
      wr(16'hFF45, 8'h05);
      wr(16'hFF41, 8'h40);
      rd("lyc_readback", 8'h01, 2'd2, 16'hFF45, 8'h05);
      exp_irq("stat_lyc5", 1'b0, 8'h05, 2'd2);
      run(4 * 456);
      rd("stat_c6", 8'h05, 2'd2, 16'hFF41, 8'hC6);

      // Coincidence + mode0: handover at line 7 entry must not re-fire.
      wr(16'hFF41, 8'h48);
      wr(16'hFF45, 8'h07);
      exp_irq("stat_m0_l5", 1'b0, 8'h05, 2'd0);
      run(252);
      chk("line5_mode0", 8'h05, 2'd0);
      exp_irq("stat_m0_l6", 1'b0, 8'h06, 2'd0);
      run(456);
      chk("line6_mode0", 8'h06, 2'd0);
      run(456);
      rd("stat_cc", 8'h07, 2'd0, 16'hFF41, 8'hCC);

      // Mode0+mode2 sources: the back-to-back mode0->mode2 stays high, mode0 entry fires.
      wr(16'hFF41, 8'h28);
      exp_irq("stat_m0_l8", 1'b0, 8'h08, 2'd0);
      run(456);
      chk("line8_mode0", 8'h08, 2'd0);
      wr(16'hFF41, 8'h20);
      exp_irq("stat_m2_l9", 1'b0, 8'h09, 2'd2);
      run(204);
      chk("line9_mode2", 8'h09, 2'd2);
      wr(16'hFF41, 8'h00);

      // Disable mid-line, ticks ignored, re-enable from line 0 dot 0.
      run(100);
      chk("line9_mode3", 8'h09, 2'd3);
      wr(16'hFF40, 8'h00);
      rd("disable_ly0", 8'h00, 2'd0, 16'hFF44, 8'h00);
      run(600);
      rd("disabled_idle", 8'h00, 2'd0, 16'hFF40, 8'h00);
      wr(16'hFF40, 8'h80);
      chk("reenable", 8'h00, 2'd2);
      run(79);
      chk("reenable_dot79", 8'h00, 2'd2);
      run(1);
      chk("reenable_dot80", 8'h00, 2'd3);

      // Full frame: one vblank pulse at line 144, wrap to line 0 with no second pulse.
      exp_irq("vblank", 1'b1, 8'h90, 2'd1);
      run(144 * 456 - 80);
      rd("vblank_ly90", 8'h90, 2'd1, 16'hFF44, 8'h90);
      run(10 * 456);
      chk("frame_wrap", 8'h00, 2'd2);

      // LY write coinciding with the last-dot tick wins.
      run(456 + 455);
      chk("line1_dot455", 8'h01, 2'd0);
      tick = 1'b1;
      addr = 16'hFF44;
      data_in = 8'h33;
      mem_we = 1'b1;
      @(posedge clock);
      #1;
      tick = 1'b0;
      mem_we = 1'b0;
      addr = 16'h0000;
      rd("ly_write_wins", 8'h00, 2'd2, 16'hFF44, 8'h00);
      run(79);
      chk("ly_write_dot79", 8'h00, 2'd2);
      run(1);
      chk("ly_write_dot80", 8'h00, 2'd3);

      // Asynchronous reset mid-line: no pulse, timer stays off afterwards.
      wr(16'hFF41, 8'h28);
      reset = 1'b1;
      chk("reset_mid", 8'h00, 2'd0);
      reset = 1'b0;
      run(300);
      chk("after_reset_idle", 8'h00, 2'd0);
      rd("after_reset_lcdc", 8'h00, 2'd0, 16'hFF40, 8'h00);
      rd("after_reset_stat", 8'h00, 2'd0, 16'hFF41, 8'h84);

      repeat (4) @(posedge clock);
      done = 1'b1;
      repeat (3) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
